// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU sequencer: state encoding, IR field
// positions and the unconditional-jump code.
package cpu16_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  typedef enum logic [2:0] {
    FETCH  = ST_FETCH,
    DECODE = ST_DECODE,
    EXEC   = ST_EXEC,
    UPDATE = ST_UPDATE,
    HALT   = ST_HALT
  } state_t;

  localparam int IR_CBIT   = 15;
  localparam int IR_JMP_HI = 2;
  localparam int IR_JMP_LO = 0;

  localparam logic [2:0] JMP_ALWAYS = 3'b111;

  function automatic logic [2:0] jmp_field(input logic [15:0] word);
    return word[IR_JMP_HI:IR_JMP_LO];
  endfunction

endpackage

// File: rtl/jump_cond_eval.sv
// Combinational jump condition: a C-instruction jumps when any selected
// condition bit (lt/eq/gt) matches the ALU flags; A-instructions never jump.
module jump_cond_eval
  import cpu16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] ir,
  input  logic             zr,
  input  logic             ng,
  output logic             take
);

  logic [2:0] jmp;
  logic       unused_ir;

  assign jmp       = jmp_field(ir[15:0]);
  assign unused_ir = ^ir;

  assign take = ir[IR_CBIT] & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/exec/update sequencer driving the PC controls, instruction fetch
// handshake and IR; detects self-jump halt and fetch timeout.
module pc_sequencer
  import cpu16_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             restart,
  input  logic [WIDTH-1:0] pc_out,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  input  logic [WIDTH-1:0] a_reg,
  input  logic             alu_zr,
  input  logic             alu_ng,
  input  logic             mem_busy,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] pc_in,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             pc_reset,
  output logic [WIDTH-1:0] ir,
  output logic             exec_en,
  output logic             halted,
  output logic             fault,
  output logic [15:0]      retired,
  output state_t           state
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  // Handshake: an instruction is accepted only in a cycle where imem_req and
  // imem_ack are both high; ack while req is low carries no meaning.
  state_t     state_q, next_state;
  logic [7:0] wait_cnt;
  logic       jump_always_q, take_q, take;
  logic       set_fault, set_halt, retire;

  jump_cond_eval #(.WIDTH(WIDTH)) u_jump_cond_eval (
    .ir   (ir),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .take (take)
  );

  assign state     = state_q;
  assign pc_reset  = reset | restart;
  assign pc_in     = a_reg;
  assign imem_addr = imem_req ? pc_out : '0;

  always_comb begin
    next_state = state_q;
    imem_req   = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    exec_en    = 1'b0;
    set_fault  = 1'b0;
    set_halt   = 1'b0;
    retire     = 1'b0;
    if (reset || restart) begin
      next_state = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          imem_req = run;
          if (run && imem_ack) begin
            next_state = DECODE;
          end else if (run && wait_cnt == CNT_LAST) begin
            next_state = HALT;
            set_fault  = 1'b1;
          end
        end
        DECODE: next_state = EXEC;
        EXEC: begin
          exec_en = 1'b1;
          if (!mem_busy) next_state = UPDATE;
        end
        UPDATE: begin
          // A jump to its own address can never make progress, so stop here.
          if (jump_always_q && (a_reg == pc_out)) begin
            next_state = HALT;
            set_halt   = 1'b1;
          end else begin
            pc_load    = take_q;
            pc_inc     = ~take_q;
            retire     = 1'b1;
            next_state = FETCH;
          end
        end
        HALT:    next_state = HALT;
        default: next_state = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FETCH;
      wait_cnt      <= '0;
      ir            <= '0;
      jump_always_q <= 1'b0;
      take_q        <= 1'b0;
      halted        <= 1'b0;
      fault         <= 1'b0;
      retired       <= '0;
    end else begin
      state_q <= next_state;
      if (restart || next_state != FETCH) wait_cnt <= '0;
      else if (imem_req && !imem_ack)     wait_cnt <= wait_cnt + 8'd1;
      if (imem_req && imem_ack) ir <= imem_data;
      if (state_q == DECODE)
        jump_always_q <= ir[IR_CBIT] && (jmp_field(ir[15:0]) == JMP_ALWAYS);
      // Flags are only trustworthy on the last EXEC cycle.
      if (state_q == EXEC && !mem_busy) take_q <= take;
      if (restart) begin
        halted <= 1'b0;
        fault  <= 1'b0;
      end else begin
        if (set_halt)  halted <= 1'b1;
        if (set_fault) fault  <= 1'b1;
      end
      if (retire) retired <= retired + 16'd1;
    end
  end

endmodule
